// File: rtl/seq_event_monitor.sv
// Monitors the upstream two-flop circuit: detects serial 1101 on z (overlapping),
// keeps saturating match / ones / state-change counts, and offers snapshot-and-clear.
module seq_event_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             z,
  input  logic             A,
  input  logic             B,
  input  logic             clear,
  input  logic             snap,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] trans_cnt,
  output logic [CNT_W-1:0] snap_match,
  output logic [CNT_W-1:0] snap_ones,
  output logic [CNT_W-1:0] snap_trans,
  output logic             snap_valid,
  output logic             sat
);

  typedef enum logic [1:0] {IDLE, G1, G11, G110} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_p1, state_nxt;
  logic [1:0]       prev_ab_p1;
  logic             prev_vld_p1;
  logic             match_nxt;
  logic             trans_ev;
  logic             sat_nxt;
  logic [CNT_W-1:0] match_cnt_nxt, ones_cnt_nxt, trans_cnt_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic hits_max(input logic [CNT_W-1:0] v);
    return v == CNT_MAX;
  endfunction

  // Stage p0 -> p1: detector state register
  always_ff @(posedge clk) begin
    if (reset || clear) state_p1 <= IDLE;
    else if (en)        state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p1;
    unique case (state_p1)
      IDLE: state_nxt = z ? G1   : IDLE;
      G1:   state_nxt = z ? G11  : IDLE;
      G11:  state_nxt = z ? G11  : G110;
      G110: state_nxt = z ? G1   : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    match_nxt     = en && (state_p1 == G110) && z;
    trans_ev      = en && prev_vld_p1 && ({A, B} != prev_ab_p1);
    match_cnt_nxt = sat_inc(match_cnt, match_nxt);
    ones_cnt_nxt  = sat_inc(ones_cnt, en && z);
    trans_cnt_nxt = sat_inc(trans_cnt, trans_ev);
    sat_nxt       = sat || hits_max(match_cnt_nxt) || hits_max(ones_cnt_nxt)
                        || hits_max(trans_cnt_nxt);
  end

  // Stage p0 -> p1: counters, snapshots and sample history
  always_ff @(posedge clk) begin
    if (reset) begin
      match       <= 1'b0;
      match_cnt   <= '0;
      ones_cnt    <= '0;
      trans_cnt   <= '0;
      snap_match  <= '0;
      snap_ones   <= '0;
      snap_trans  <= '0;
      snap_valid  <= 1'b0;
      sat         <= 1'b0;
      prev_ab_p1  <= 2'b00;
      prev_vld_p1 <= 1'b0;
    end else if (clear) begin
      match       <= 1'b0;
      match_cnt   <= '0;
      ones_cnt    <= '0;
      trans_cnt   <= '0;
      snap_valid  <= 1'b0;
      sat         <= 1'b0;
      prev_vld_p1 <= 1'b0;
    end else begin
      match <= match_nxt;
      if (snap) begin
        snap_match <= match_cnt_nxt;
        snap_ones  <= ones_cnt_nxt;
        snap_trans <= trans_cnt_nxt;
        match_cnt  <= '0;
        ones_cnt   <= '0;
        trans_cnt  <= '0;
        sat        <= 1'b0;
        snap_valid <= 1'b1;
      end else begin
        match_cnt  <= match_cnt_nxt;
        ones_cnt   <= ones_cnt_nxt;
        trans_cnt  <= trans_cnt_nxt;
        sat        <= sat_nxt;
        snap_valid <= 1'b0;
      end
      // Snapshot leaves the detector history alone so a match can span it
      if (en) begin
        prev_ab_p1  <= {A, B};
        prev_vld_p1 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_event_monitor.sv
// Bench for seq_event_monitor: directed table, hand sequences and random traffic
// against a sliding-window model, on an 8-bit and a 2-bit counter instance.
module tb_seq_event_monitor;

  logic clk = 1'b0;
  logic reset, en, z, A, B, clear, snap;

  logic       d0_match, d0_sv, d0_sat;
  logic [7:0] d0_mc, d0_ones, d0_tr, d0_smc, d0_so, d0_st;
  logic       d1_match, d1_sv, d1_sat;
  logic [1:0] d1_mc, d1_ones, d1_tr, d1_smc, d1_so, d1_st;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  seq_event_monitor #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .z(z), .A(A), .B(B), .clear(clear), .snap(snap),
    .match(d0_match), .match_cnt(d0_mc), .ones_cnt(d0_ones), .trans_cnt(d0_tr),
    .snap_match(d0_smc), .snap_ones(d0_so), .snap_trans(d0_st),
    .snap_valid(d0_sv), .sat(d0_sat)
  );

  seq_event_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .z(z), .A(A), .B(B), .clear(clear), .snap(snap),
    .match(d1_match), .match_cnt(d1_mc), .ones_cnt(d1_ones), .trans_cnt(d1_tr),
    .snap_match(d1_smc), .snap_ones(d1_so), .snap_trans(d1_st),
    .snap_valid(d1_sv), .sat(d1_sat)
  );

  // Reference model: pattern found from the last four enabled samples since reset/clear
  logic [3:0] hist;
  int         hist_n;
  bit         pv;
  logic [1:0] pab;
  int         mx[2] = '{255, 3};
  int         m_mc[2], m_ones[2], m_tr[2], m_smc[2], m_so[2], m_st[2];
  bit         m_match[2], m_sv[2], m_sat[2];

  function automatic int inc_cap(int v, bit inc, int cap);
    if (inc && v < cap) return v + 1;
    return v;
  endfunction

  task automatic model_update();
    bit mt, tr;
    int nmc, nones, ntr;
    mt = 0;
    tr = 0;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_mc[k] = 0; m_ones[k] = 0; m_tr[k] = 0; m_smc[k] = 0; m_so[k] = 0; m_st[k] = 0;
        m_match[k] = 0; m_sv[k] = 0; m_sat[k] = 0;
      end
      hist_n = 0;
      pv = 0;
    end else if (clear) begin
      for (int k = 0; k < 2; k++) begin
        m_mc[k] = 0; m_ones[k] = 0; m_tr[k] = 0;
        m_match[k] = 0; m_sv[k] = 0; m_sat[k] = 0;
      end
      hist_n = 0;
      pv = 0;
    end else begin
      if (en) begin
        hist = {hist[2:0], z};
        if (hist_n < 4) hist_n++;
        mt = (hist_n == 4) && (hist == 4'b1101);
        tr = pv && ({A, B} != pab);
        pab = {A, B};
        pv = 1;
      end
      for (int k = 0; k < 2; k++) begin
        nmc   = inc_cap(m_mc[k], mt, mx[k]);
        nones = inc_cap(m_ones[k], en && z, mx[k]);
        ntr   = inc_cap(m_tr[k], tr, mx[k]);
        m_match[k] = mt;
        if (snap) begin
          m_smc[k] = nmc; m_so[k] = nones; m_st[k] = ntr;
          m_mc[k] = 0; m_ones[k] = 0; m_tr[k] = 0;
          m_sat[k] = 0;
          m_sv[k] = 1;
        end else begin
          m_mc[k] = nmc; m_ones[k] = nones; m_tr[k] = ntr;
          m_sat[k] = m_sat[k] || nmc == mx[k] || nones == mx[k] || ntr == mx[k];
          m_sv[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("w8_match", d0_match, m_match[0]);  chk("w8_match_cnt", d0_mc, m_mc[0]);
    chk("w8_ones", d0_ones, m_ones[0]);     chk("w8_trans", d0_tr, m_tr[0]);
    chk("w8_snap_match", d0_smc, m_smc[0]); chk("w8_snap_ones", d0_so, m_so[0]);
    chk("w8_snap_trans", d0_st, m_st[0]);   chk("w8_snap_valid", d0_sv, m_sv[0]);
    chk("w8_sat", d0_sat, m_sat[0]);
    chk("w2_match", d1_match, m_match[1]);  chk("w2_match_cnt", d1_mc, m_mc[1]);
    chk("w2_ones", d1_ones, m_ones[1]);     chk("w2_trans", d1_tr, m_tr[1]);
    chk("w2_snap_match", d1_smc, m_smc[1]); chk("w2_snap_ones", d1_so, m_so[1]);
    chk("w2_snap_trans", d1_st, m_st[1]);   chk("w2_snap_valid", d1_sv, m_sv[1]);
    chk("w2_sat", d1_sat, m_sat[1]);
  endtask

  task automatic step(input bit r, input bit e, input bit zz, input bit [1:0] ab,
                      input bit c, input bit s);
    reset = r; en = e; z = zz; A = ab[1]; B = ab[0]; clear = c; snap = s;
    @(posedge clk);
    #1;
    model_update();
    check_all();
  endtask

  typedef struct {
    bit       rst, en, z;
    bit [1:0] ab;
    bit       clr, snp;
    int       em, emc, eones, etr, esv, esm, eso;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit zz, bit [1:0] ab, bit c, bit s,
                              int em, int emc, int eones, int etr, int esv, int esm, int eso);
    vec_t v;
    v.rst = r; v.en = e; v.z = zz; v.ab = ab; v.clr = c; v.snp = s;
    v.em = em; v.emc = emc; v.eones = eones; v.etr = etr; v.esv = esv; v.esm = esm; v.eso = eso;
    return v;
  endfunction

  int w2_ones_exp[4] = '{1, 2, 3, 3};
  int w2_sat_exp[4]  = '{0, 0, 1, 1};

  initial begin
    reset = 1; en = 0; z = 0; A = 0; B = 0; clear = 0; snap = 0;
    hist = '0; hist_n = 0; pv = 0; pab = '0;

    // 1101 twice with overlap
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0,0,2,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,2,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 1,1,3,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0,1,4,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,1,4,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 1,2,5,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,2,5,0,0,0,0));
    // {A,B} transitions, then the same with en=0 on the 01 sample
    tbl.push_back(mk(0,1,0,0,1,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0, 0,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,3,0,0, 0,0,0,2,0,0,0));
    tbl.push_back(mk(0,1,0,3,0,0, 0,0,0,2,0,0,0));
    tbl.push_back(mk(0,1,0,2,0,0, 0,0,0,3,0,0,0));
    tbl.push_back(mk(0,1,0,0,1,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,3,0,0, 0,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,3,0,0, 0,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,2,0,0, 0,0,0,2,0,0,0));
    // snapshot on the 4th sample; the overlap carries across
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 0,0,2,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,2,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,1, 1,0,0,0,1,1,3));
    tbl.push_back(mk(0,1,1,0,0,0, 0,0,1,0,0,1,3));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,1,0,0,1,3));
    tbl.push_back(mk(0,1,1,0,0,0, 1,1,2,0,0,1,3));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].z, tbl[i].ab, tbl[i].clr, tbl[i].snp);
      chk($sformatf("tbl%0d_match", i), d0_match, tbl[i].em);
      chk($sformatf("tbl%0d_match_cnt", i), d0_mc, tbl[i].emc);
      chk($sformatf("tbl%0d_ones", i), d0_ones, tbl[i].eones);
      chk($sformatf("tbl%0d_trans", i), d0_tr, tbl[i].etr);
      chk($sformatf("tbl%0d_snap_valid", i), d0_sv, tbl[i].esv);
      chk($sformatf("tbl%0d_snap_match", i), d0_smc, tbl[i].esm);
      chk($sformatf("tbl%0d_snap_ones", i), d0_so, tbl[i].eso);
    end

    // 2-bit counters saturate and sat holds until snap
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 0, 0);
      chk($sformatf("w2sat_ones%0d", i), d1_ones, w2_ones_exp[i]);
      chk($sformatf("w2sat_sat%0d", i), d1_sat, w2_sat_exp[i]);
    end
    step(0, 1, 0, 0, 0, 1);
    chk("w2sat_snap_ones", d1_so, 3);
    chk("w2sat_sat_after_snap", d1_sat, 0);
    chk("w2sat_ones_after_snap", d1_ones, 0);
    chk("w2sat_snap_valid", d1_sv, 1);

    // clear wins over snap and abandons the partial 110
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 1);
    chk("clrsnap_snap_valid", d0_sv, 0);
    chk("clrsnap_snap_ones", d0_so, 1);
    chk("clrsnap_ones", d0_ones, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("clrsnap_match", d0_match, 0);
    chk("clrsnap_ones_after", d0_ones, 1);
    chk("clrsnap_snap_ones_hold", d0_so, 1);

    // reset while in G110 with non-zero counters and snapshots
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    step(0, 1, 1, 3, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("g110_match_cnt_pre", d0_mc, 1);
    step(1, 1, 1, 0, 0, 0);
    chk("rst_match", d0_match, 0);   chk("rst_match_cnt", d0_mc, 0);
    chk("rst_ones", d0_ones, 0);     chk("rst_trans", d0_tr, 0);
    chk("rst_snap_ones", d0_so, 0);  chk("rst_snap_valid", d0_sv, 0);
    chk("rst_sat", d0_sat, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("rst_no_match", d0_match, 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit [1:0] ab;
      ab = ($urandom_range(0, 1) == 0) ? {A, B} : 2'($urandom_range(0, 3));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) != 0, ab,
           $urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
